tick_uart_tx: RTL and testbench
===============================

TICK_UART_TX -- requirements
Module: tick_uart_tx

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, payload bits per frame (legal 5..9).
REQ-002 The block SHALL have parameter STOP_BITS, default 1, stop-bit periods per frame (legal 1 or 2).
REQ-003 The block SHALL have parameter PARITY_EN, default 0, 1 = insert even-parity bit after data.
REQ-004 The block SHALL have port clk_FPGA, input, 1 bit, the single system clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-006 The block SHALL have port baud_clock, input, 1 bit, divided square wave from the clock divider, synchronous to clk_FPGA; one rising edge per bit period.
REQ-007 The block SHALL have port tx_start, input, 1 bit, request to send tx_data.
REQ-008 The block SHALL have port tx_data, input, DATA_BITS bits, payload, LSB transmitted first.
REQ-009 The block SHALL have port tx_serial, output, 1 bit, serial line, idle high.
REQ-010 The block SHALL have port tx_busy, output, 1 bit, frame in progress.
REQ-011 The block SHALL have port tx_done, output, 1 bit, one-cycle pulse at frame end.

Function
REQ-012 The block SHALL register baud_clock each cycle and SHALL generate tick = baud_clock AND NOT registered value, high for exactly one clk_FPGA cycle per baud_clock rising edge.
REQ-013 The block SHALL implement FSM states IDLE, SYNC, START, DATA, PARITY, STOP; state changes other than IDLE->SYNC SHALL occur only on tick.
REQ-014 In IDLE the block SHALL accept tx_start=1, capture tx_data into an internal shift register, and enter SYNC next cycle; tx_busy=1 from that next cycle.
REQ-015 The block SHALL ignore a tick coincident with the accept cycle; SYNC SHALL hold tx_serial=1 until the next tick, then enter START.
REQ-016 START SHALL drive tx_serial=0 for one bit period, then enter DATA.
REQ-017 DATA SHALL drive bit i (i=0..DATA_BITS-1, LSB first) for one bit period each, using a bit counter of ceil(log2(DATA_BITS)) bits; after bit DATA_BITS-1 it SHALL enter PARITY if PARITY_EN=1, else STOP.
REQ-018 PARITY SHALL drive XOR of all captured data bits (even parity) for one bit period, then enter STOP.
REQ-019 STOP SHALL drive tx_serial=1 for STOP_BITS bit periods; on the tick ending the last stop period the block SHALL enter IDLE, pulse tx_done=1 for exactly that one cycle, and drop tx_busy in the same cycle.
REQ-020 The block SHALL ignore tx_start in every state except IDLE, including the tx_done cycle; a request held into the following IDLE cycle SHALL be accepted.
REQ-021 Changes on tx_data after the accept cycle SHALL NOT affect the frame in progress.
REQ-022 tx_serial, tx_busy, tx_done SHALL be driven from registers (no combinational path from inputs).
REQ-023 Frame length SHALL be exactly 1+DATA_BITS+PARITY_EN+STOP_BITS bit periods from START entry to tx_done.

Reset
REQ-024 While reset=1 the block SHALL asynchronously force state=IDLE, tx_serial=1, tx_busy=0, tx_done=0, bit and stop counters=0, shift register=0.
REQ-025 The registered baud_clock SHALL reset to 1, so that no spurious tick occurs on reset release when baud_clock=1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no tx_done pulse; the first tx_start after release SHALL produce a complete frame.

Verification
REQ-027 Bench SHALL cover: reset held 20 cycles with baud_clock toggling every 5 cycles -> tx_serial=1, tx_busy=0, tx_done=0 throughout and after release.
REQ-028 Bench SHALL cover: defaults, bit period 10 cycles, send 0xA5 -> line 0,1,0,1,0,0,1,0,1,1 each held 10 cycles, tx_busy high cycle after accept, single tx_done at stop end.
REQ-029 Bench SHALL cover: PARITY_EN=1, send 0x07 -> parity bit 1, frame 11 bit periods; send 0x03 -> parity bit 0.
REQ-030 Bench SHALL cover: tx_start with 0xFF during a 0x3C frame -> 0x3C frame unchanged, exactly one tx_done, 0xFF never sent.
REQ-031 Bench SHALL cover: reset pulse during data bit 3 -> tx_serial=1 and tx_busy=0 in the same cycle, no tx_done; next request 0x81 sends a full, correct frame.
REQ-032 Bench SHALL cover: tx_start high only in tx_done cycle -> ignored; held one more cycle -> accepted, second frame starts on the next tick.

Source files
------------

// File: rtl/tick_uart_tx.sv
// Tick-paced UART transmitter: 1 start bit, DATA_BITS payload bits (LSB first),
// optional even parity, STOP_BITS stop bits. Bit timing comes from the rising edges of baud_clock.
module tick_uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int PARITY_EN = 0
) (
    input  logic                 clk_FPGA,
    input  logic                 reset,
    input  logic                 baud_clock,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int                CNT_W     = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 baud_q;
    logic                 tick;
    logic                 accept;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic [CNT_W-1:0]     bit_cnt;
    logic [CNT_W-1:0]     bit_cnt_next;
    logic                 stop_cnt;
    logic                 stop_cnt_next;
    logic                 parity_bit;
    logic                 parity_next;
    logic                 serial_next;
    logic                 done_next;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

    // baud_q resets high so a baud_clock already high at release is not seen as an edge.
    assign tick   = baud_clock & ~baud_q;
    // The tx_done cycle is already IDLE, but a request there must be ignored.
    assign accept = (state == IDLE) && tx_start && !tx_done;

    always_ff @(posedge clk_FPGA or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt;
        stop_cnt_next = stop_cnt;
        parity_next   = parity_bit;
        done_next     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    shift_next    = tx_data;
                    parity_next   = even_parity(tx_data);
                    bit_cnt_next  = '0;
                    stop_cnt_next = 1'b0;
                    state_next    = SYNC;
                end
            end
            SYNC: begin
                if (tick) begin
                    state_next = START;
                end
            end
            START: begin
                if (tick) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_next = {1'b0, shift_reg[DATA_BITS-1:1]};
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_next = '0;
                        state_next   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop_cnt == STOP_LAST) begin
                        stop_cnt_next = 1'b0;
                        state_next    = IDLE;
                        done_next     = 1'b1;
                    end else begin
                        stop_cnt_next = stop_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Line level is decided from the upcoming state so the output can be a plain register.
    always_comb begin
        case (state_next)
            START:   serial_next = 1'b0;
            DATA:    serial_next = shift_next[0];
            PARITY:  serial_next = parity_next;
            default: serial_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk_FPGA or posedge reset) begin
        if (reset) begin
            baud_q     <= 1'b1;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            parity_bit <= 1'b0;
            tx_serial  <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            baud_q     <= baud_clock;
            shift_reg  <= shift_next;
            bit_cnt    <= bit_cnt_next;
            stop_cnt   <= stop_cnt_next;
            parity_bit <= parity_next;
            tx_serial  <= serial_next;
            tx_busy    <= (state_next != IDLE);
            tx_done    <= done_next;
        end
    end

endmodule

// File: tb/tb_tick_uart_tx.sv
// Bench for tick_uart_tx: a default 8N1 instance and an 8E1 instance share clock, baud and reset;
// expected frames are hand-written bit strings queued at issue time and checked by a line monitor.
module tb_tick_uart_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       baud_clock = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       sel = 1'b0;

    logic tx_serial_d, tx_busy_d, tx_done_d;
    logic tx_serial_p, tx_busy_p, tx_done_p;
    wire  tx_start_d = tx_start & ~sel;
    wire  tx_start_p = tx_start & sel;
    wire  line = sel ? tx_serial_p : tx_serial_d;
    wire  busy = sel ? tx_busy_p : tx_busy_d;
    wire  done = sel ? tx_done_p : tx_done_d;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    done_cnt = 0;
    logic  rst_seen = 1'b0;
    string exp_q[$];

    tick_uart_tx dut_d (
        .clk_FPGA  (clk),
        .reset     (reset),
        .baud_clock(baud_clock),
        .tx_start  (tx_start_d),
        .tx_data   (tx_data),
        .tx_serial (tx_serial_d),
        .tx_busy   (tx_busy_d),
        .tx_done   (tx_done_d)
    );

    tick_uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(1)) dut_p (
        .clk_FPGA  (clk),
        .reset     (reset),
        .baud_clock(baud_clock),
        .tx_start  (tx_start_p),
        .tx_data   (tx_data),
        .tx_serial (tx_serial_p),
        .tx_busy   (tx_busy_p),
        .tx_done   (tx_done_p)
    );

    always #5 clk = ~clk;

    // Bit period of 10 clocks, toggled away from the active edge.
    initial begin
        forever begin
            repeat (5) @(negedge clk);
            baud_clock = ~baud_clock;
        end
    end

    always @(negedge clk) if (tx_done_d || tx_done_p) done_cnt++;
    always @(posedge reset) rst_seen = 1'b1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_str(input string name, input string act, input string req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %s, expected %s (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Called at the negedge of the first low (start) cycle.
    task automatic run_frame();
        string exp;
        string act;
        int    n;
        int    bad_cycles;
        int    idle_cycles;
        bit    aborted;
        check("expected frame queued", int'(exp_q.size() > 0), 1);
        if (exp_q.size() == 0) return;
        exp = exp_q.pop_front();
        n = exp.len();
        act = "";
        bad_cycles = 0;
        idle_cycles = 0;
        aborted = 1'b0;
        rst_seen = 1'b0;
        for (int cyc = 0; cyc < 10 * n && !aborted; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (rst_seen) begin
                aborted = 1'b1;
            end else begin
                if (cyc % 10 == 5) act = {act, (line ? "1" : "0")};
                if (line !== (exp.substr(cyc / 10, cyc / 10) == "1")) bad_cycles++;
                if (busy !== 1'b1) idle_cycles++;
            end
        end
        if (!aborted) begin
            check_str("frame bits", act, exp);
            check("cycles off expected level", bad_cycles, 0);
            check("cycles with busy low in frame", idle_cycles, 0);
            @(negedge clk);
            check("tx_done at frame end", int'(done), 1);
            check("tx_busy low at frame end", int'(busy), 0);
            @(negedge clk);
            check("tx_done one cycle wide", int'(done), 0);
        end
    endtask

    initial begin
        logic line_q;
        line_q = 1'b1;
        forever begin
            @(negedge clk);
            if (line_q === 1'b1 && line === 1'b0) run_frame();
            line_q = line;
        end
    end

    task automatic wait_start(output int n);
        n = 0;
        while (line !== 1'b0 && n < 12) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("tx_done seen before timeout", int'(done === 1'b1), 1);
    endtask

    task automatic send(input logic [7:0] d, input string frame);
        int n;
        exp_q.push_back(frame);
        tx_data = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data = ~d;
        check("tx_busy cycle after accept", int'(busy), 1);
        wait_start(n);
        check_range("cycles from accept to start bit", n, 1, 10);
    endtask

    initial begin
        int n;
        int dsave;

        repeat (20) begin
            @(negedge clk);
            check("idle outputs in reset",
                  int'({tx_serial_d, tx_busy_d, tx_done_d, tx_serial_p, tx_busy_p, tx_done_p}), 6'b100100);
        end
        reset = 1'b0;
        repeat (15) begin
            @(negedge clk);
            check("idle outputs after reset",
                  int'({tx_serial_d, tx_busy_d, tx_done_d, tx_serial_p, tx_busy_p, tx_done_p}), 6'b100100);
        end

        send(8'hA5, "0101001011");
        wait_done();
        repeat (7) @(negedge clk);

        send(8'h3C, "0001111001");
        repeat (25) @(negedge clk);
        tx_data = 8'hFF;
        tx_start = 1'b1;
        repeat (3) @(negedge clk);
        tx_start = 1'b0;
        tx_data = 8'h00;
        wait_done();
        repeat (30) @(negedge clk);
        check("no frame for request made while busy", int'(busy), 0);

        send(8'h37, "0111011001");
        repeat (43) @(negedge clk);
        #2 reset = 1'b1;
        #1 check("outputs forced by async reset", int'({tx_serial_d, tx_busy_d, tx_done_d}), 3'b100);
        dsave = done_cnt;
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (25) @(negedge clk);
        check("no tx_done after aborted frame", done_cnt, dsave);
        check("idle after aborted frame", int'({line, busy}), 2'b10);

        send(8'h81, "0100000011");
        wait_done();
        repeat (5) @(negedge clk);

        send(8'h5A, "0010110101");
        wait_done();
        tx_data = 8'h11;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        check("start in tx_done cycle ignored", int'(busy), 0);
        repeat (20) @(negedge clk);
        check("still idle after ignored start", int'(busy), 0);

        send(8'hC3, "0110000111");
        wait_done();
        exp_q.push_back("0100110011");
        tx_data = 8'h99;
        tx_start = 1'b1;
        @(negedge clk);
        check("held start not taken in tx_done cycle", int'(busy), 0);
        @(negedge clk);
        tx_start = 1'b0;
        check("held start accepted next cycle", int'(busy), 1);
        wait_start(n);
        check_range("second frame starts on next tick", n, 1, 10);
        wait_done();
        repeat (5) @(negedge clk);

        sel = 1'b1;
        repeat (5) @(negedge clk);
        send(8'h07, "01110000011");
        wait_done();
        repeat (3) @(negedge clk);
        send(8'h03, "01100000001");
        wait_done();
        repeat (10) @(negedge clk);

        check("expected frames left over", exp_q.size(), 0);
        check("total tx_done pulses", done_cnt, 8);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
